cpu_seq_ctrl: RTL
=================

# cpu_seq_ctrl

Multi-cycle sequencer for the 8-bit CPU datapath (imem, decoder, control, regfile, alu, datamem).
- Replaces the free-running dual-clock PC update with a single-clock FSM.
- The FSM steps each instruction through fetch, decode, execute, optional memory access and writeback.
- It owns the program counter and gates every architectural write (instruction latch, regfile write, data-memory access).
- It supports run/single-step/halt control and a handshake to a data memory that may take multiple cycles.

## Interface
Parameters:
- PC_W, 8, program counter / branch offset width
- CNT_W, 16, retired-instruction counter width
- HALT_OP, 4'hF, opcode that halts the core

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; while high, instructions execute back-to-back
- step  in  1  pulse; in IDLE with run low, executes exactly one instruction
- opcode  in  4  from decoder
- nia  in  1  from control; 0 = jump by jaddr
- br  in  1  from alu; branch taken
- jaddr  in  PC_W  decoder addr field
- imm  in  PC_W  decoder immediate (branch offset)
- mem_read  in  1  from control
- mem_write  in  1  from control
- reg_write_req  in  1  from control
- mem_ack  in  1  data memory completion
- pc  out  PC_W  current PC to imem
- inst_ld  out  1  latch instruction register
- rf_we  out  1  regfile write enable
- mem_req  out  1  data memory request
- mem_we  out  1  qualifies mem_req as a write
- state  out  3  FSM state encoding
- idle  out  1  state == IDLE
- halt_seen  out  1  sticky, set by HALT_OP
- retired  out  CNT_W  instructions completed

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: if halt_seen, stay. Else if run or step, go to FETCH. Else stay.
- FETCH: inst_ld=1 for one cycle, then DECODE.
- DECODE: no outputs; operand read settles; go to EXEC.
- EXEC:
  - opcode==HALT_OP: set halt_seen, go to IDLE. PC is not advanced; retired does not increment.
  - Else if mem_read|mem_write: go to MEM.
  - Else: go to WB.
- MEM: mem_req=1, mem_we=mem_write; held until mem_ack is sampled high in MEM, then go to WB. mem_ack outside MEM is ignored.
- WB:
  - rf_we=reg_write_req for exactly this cycle.
  - PC update: nia==0 gives pc+jaddr; else br gives pc+imm; else pc+1. All sums are modulo 2^PC_W.
  - retired increments, wrapping modulo 2^CNT_W.
  - Next state: FETCH if run, else IDLE.
- Priority: nia==0 over br; run over step; step outside IDLE is ignored and not queued.
- halt_seen clears only on rst.

## Timing
- Reset values: pc=0, state=IDLE, idle=1, halt_seen=0, retired=0. inst_ld, rf_we, mem_req and mem_we are all 0.
- rst asserted in any state: next edge forces the reset values. An in-flight mem_req drops that cycle, and there is no writeback.
- All control outputs are registered-state decodes: Moore, glitch-free, no combinational path from inputs. The exception is mem_we, which follows mem_write while in MEM.
- Non-memory instruction: 4 cycles (FETCH through WB).
- Memory instruction: 5+N cycles, where N = cycles in MEM before mem_ack. mem_ack high on the first MEM cycle gives N=0.
- PC and retired update on the edge that leaves WB. The new PC is visible in the following FETCH.
- Inputs from decoder, control and alu must be stable from DECODE through WB; the sequencer samples them in EXEC and WB only.

## Structure
- Package cpu_seq_pkg: state enum (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5), HALT_OP default, PC_W/CNT_W defaults.
- One sub-module, pc_next_calc: combinational next-PC select/add from pc, nia, br, jaddr, imm. It is reused by the branch-target checker.

## Test plan
- Reset then run=1, program of plain ALU ops: inst_ld pulses every 4 cycles; pc = 0,1,2,3; rf_we one cycle per WB; retired=3 after 12 cycles.
- Load at pc=5, mem_ack delayed 3 cycles: mem_req high exactly 4 cycles, mem_we=0; rf_we in WB; pc becomes 6; total 8 cycles.
- At pc=10, br=1, imm=8'hFA: pc becomes 4. Same with nia=0, jaddr=3, br=1: pc becomes 13, since nia wins. At pc=8'hFF with a plain op: pc wraps to 0.
- run=0, step pulsed in IDLE: exactly one instruction, returns to IDLE, retired+1. A step pulse during EXEC is ignored.
- HALT_OP at pc=7: halt_seen=1, idle=1, pc stays 7, retired unchanged; run/step then have no effect until rst.
- rst asserted during MEM with mem_req high: next cycle mem_req=0, rf_we never pulses, pc=0, retired=0, state=IDLE.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and default sizes for the multi-cycle CPU sequencer.
package cpu_seq_pkg;

  localparam int         PC_W_DEF    = 8;
  localparam int         CNT_W_DEF   = 16;
  localparam logic [3:0] HALT_OP_DEF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cpu_seq_ctrl_pc_next_calc.sv
// Next-PC select/add; shared with the branch-target checker.
module pc_next_calc #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            nia,
  input  logic            br,
  input  logic [PC_W-1:0] jaddr,
  input  logic [PC_W-1:0] imm,
  output logic [PC_W-1:0] pc_nxt
);

  // Offsets are two's complement, so a plain modulo-2^PC_W add covers backward branches.
  always_comb begin
    if (!nia)
      pc_nxt = pc + jaddr;
    else if (br)
      pc_nxt = pc + imm;
    else
      pc_nxt = pc + PC_W'(1);
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Single-clock multi-cycle sequencer: owns the PC and gates every architectural write.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int         PC_W    = PC_W_DEF,
  parameter int         CNT_W   = CNT_W_DEF,
  parameter logic [3:0] HALT_OP = HALT_OP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       opcode,
  input  logic             nia,
  input  logic             br,
  input  logic [PC_W-1:0]  jaddr,
  input  logic [PC_W-1:0]  imm,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write_req,
  input  logic             mem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             inst_ld,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic             idle,
  output logic             halt_seen,
  output logic [CNT_W-1:0] retired
);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_nxt;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next (
    .pc     (pc),
    .nia    (nia),
    .br     (br),
    .jaddr  (jaddr),
    .imm    (imm),
    .pc_nxt (pc_nxt)
  );

  // Strobes are registered on the transition into their state, so each is a clean one-state pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc        <= '0;
      retired   <= '0;
      halt_seen <= 1'b0;
      inst_ld   <= 1'b0;
      rf_we     <= 1'b0;
      mem_req   <= 1'b0;
    end else begin
      inst_ld <= 1'b0;
      rf_we   <= 1'b0;
      mem_req <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!halt_seen && (run || step)) begin
            state_q <= ST_FETCH;
            inst_ld <= 1'b1;
          end
        end
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: state_q <= ST_EXEC;
        ST_EXEC: begin
          if (opcode == HALT_OP) begin
            halt_seen <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (mem_read || mem_write) begin
            state_q <= ST_MEM;
            mem_req <= 1'b1;
          end else begin
            state_q <= ST_WB;
            rf_we   <= reg_write_req;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            state_q <= ST_WB;
            rf_we   <= reg_write_req;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_WB: begin
          pc      <= pc_nxt;
          retired <= retired + CNT_W'(1);
          if (run) begin
            state_q <= ST_FETCH;
            inst_ld <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we = mem_req & mem_write;
  assign state  = state_q;
  assign idle   = (state_q == ST_IDLE);

endmodule
